dpi_stream_sequencer: RTL and testbench
=======================================

// Module: dpi_stream_sequencer
// PURPOSE
//  Upstream feeder for the per-regex cancid_* matcher wrappers. Takes a byte-wide packet stream with a flow key on SOP,
//  maps the key to a 6-bit stream id via a 64-entry flow table, then drives the shared matcher bus.
//  Sequence per packet: load_state pulse, char bytes, delayed eop pulse. Sequencing guarantees
//  matchers restore state before the first byte and save state only after the DFA pipeline drains.
// PARAMETERS
//  KEY_W      32   flow key width (hashed 5-tuple)
//  NUM_REGEX  8    number of downstream matchers; width of enable vector
//  EOP_GAP    4    cycles from last char_in_vld to eop (covers matcher in/out regs + DFA + match flag)
// PORTS
//  clk            in   1          clock
//  rst_n          in   1          reset, synchronous, active-low
//  pkt_vld        in   1          input beat valid
//  pkt_rdy        out  1          input beat accepted when pkt_vld&pkt_rdy
//  pkt_sop        in   1          first beat of packet; pkt_key valid with it
//  pkt_eop        in   1          last beat of packet
//  pkt_data       in   8          payload byte
//  pkt_key        in   KEY_W      flow key, sampled on SOP only
//  cfg_we         in   1          write enable-table entry
//  cfg_addr       in   6          stream id to configure
//  cfg_data       in   NUM_REGEX  per-regex enable mask for that stream id
//  char_in        out  8          byte to matchers
//  char_in_vld    out  1          char_in valid
//  load_state     out  1          1-cycle pulse: matchers restore/reset state for stream_id
//  stream_id      out  6          current stream id; stable from load_state through eop inclusive
//  new_stream_id  out  1          with load_state: stream freshly allocated, matchers start from state 0
//  enable         out  NUM_REGEX  per-regex enable, latched at load_state, stable through eop
//  eop            out  1          1-cycle pulse: matchers commit count and save state
//  drop_cnt       out  16         non-SOP beats discarded while idle; saturating
// BEHAVIOUR
//  Reset: all outputs 0, pkt_rdy 0, flow table all invalid, enable table all 0, evict ptr 0, FSM IDLE.
//  FSM IDLE->LOOKUP->LOAD->STREAM->DRAIN->EOP->IDLE; all matcher-bus outputs registered.
//  IDLE: pkt_rdy = pkt_vld & ~pkt_sop, so non-SOP beats are dropped (drop_cnt++, saturate at 16'hFFFF).
//    On pkt_vld&pkt_sop: register pkt_key, beat not consumed, go LOOKUP.
//  LOOKUP (1 cycle): parallel compare against all valid entries.
//    hit -> id = lowest matching index, new=0.
//    miss -> id = lowest invalid index, else evict ptr (ptr then increments mod 64); entry written valid with key; new=1.
//  LOAD: load_state=1, stream_id=id, new_stream_id=new, enable=enable_tbl[id] for exactly this cycle (L). -> STREAM.
//  STREAM: pkt_rdy=1 from cycle L+1 (the held SOP beat is consumed first). Each handshake beat drives char_in/char_in_vld
//    next cycle, so first char_in_vld >= L+2. pkt_vld low -> char_in_vld 0 that cycle (bubbles allowed).
//    Beat with pkt_eop -> DRAIN, pkt_rdy=0. SOP inside STREAM is treated as data.
//  DRAIN: counter so eop asserts exactly EOP_GAP cycles after the cycle of the last char_in_vld. EOP: eop=1 one cycle -> IDLE.
//  Next load_state is never earlier than eop+2 (IDLE+LOOKUP); eop and load_state never coincide.
//  SOP+EOP single-byte packet: one char, normal DRAIN/EOP.
//  cfg write: takes effect at the next load_state. Same-cycle write to current id does not alter the latched enable.
//  Allocation never modifies enable table. Evicting a flow reuses its slot; new_stream_id=1 discards stale matcher state.
//  rst_n mid-packet: immediate return to IDLE, no eop issued, table cleared; remaining beats of that packet dropped as non-SOP.
//  stream_id/new_stream_id/enable hold their last values in IDLE (don't care to matchers, not zeroed).
// STRUCTURE
//  Package dpi_pkg: STREAM_ID_W=6, NUM_STREAMS=64, FSM state enum, EOP_GAP default shared with matcher wrappers.
//  Sub-module dpi_flow_table: key/valid arrays, parallel compare, free/evict select, write port.
//  FSM and bus drivers stay in top.
// TESTING
//  Reset, then SOP key 0xA5A5A5A5 with 3 bytes -> load_state with id 0, new=1. First char_in_vld 2 cycles after load_state.
//    eop exactly 4 cycles after the 3rd char.
//  Same key again -> id 0, new=0; different key 0x1 -> id 1, new=1.
//  Fill 64 distinct keys, then a 65th -> id 0 evicted, new=1. A 66th -> id 1. Reuse of the 1st key -> new allocation.
//  cfg_we addr 1 data 8'h05 before packet on id 1 -> enable=8'h05 from load_state through eop.
//    cfg write during the packet -> unchanged until next packet.
//  Non-SOP beats in IDLE x3 -> drop_cnt=3, no matcher-bus activity. pkt_vld gaps in STREAM -> matching char_in_vld gaps,
//    eop timed from the last byte.
//  rst_n low for 1 cycle mid-STREAM -> no eop, outputs 0. Next SOP with the old key -> id 0, new=1.

Source files
------------

// File: rtl/dpi_pkg.sv
// Shared types and constants for the DPI stream sequencer and the matcher wrappers it feeds.
package dpi_pkg;
  localparam int unsigned STREAM_ID_W     = 6;
  localparam int unsigned NUM_STREAMS     = 64;
  localparam int unsigned EOP_GAP_DEFAULT = 4;

  typedef logic [STREAM_ID_W-1:0] stream_id_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_LOAD,
    S_STREAM,
    S_DRAIN,
    S_EOP
  } seq_state_e;
endpackage

// File: rtl/dpi_flow_table.sv
// 64-entry flow key table: parallel lookup, lowest-free or round-robin eviction allocation.
module dpi_flow_table
  import dpi_pkg::*;
#(
  parameter int unsigned KEY_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key,
  input  logic             alloc,
  output stream_id_t       id,
  output logic             new_flow
);

  logic [KEY_W-1:0]       keys [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] valid;
  stream_id_t             evict_ptr;
  stream_id_t             hit_idx;
  stream_id_t             free_idx;
  logic                   hit;
  logic                   has_free;

  // Scan from the top so the last assignment wins with the lowest index.
  always_comb begin
    hit      = 1'b0;
    has_free = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
      if (valid[NUM_STREAMS-1-i] && keys[NUM_STREAMS-1-i] == key) begin
        hit     = 1'b1;
        hit_idx = stream_id_t'(NUM_STREAMS-1-i);
      end
      if (!valid[NUM_STREAMS-1-i]) begin
        has_free = 1'b1;
        free_idx = stream_id_t'(NUM_STREAMS-1-i);
      end
    end
  end

  assign id       = hit ? hit_idx : (has_free ? free_idx : evict_ptr);
  assign new_flow = ~hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid     <= '0;
      evict_ptr <= '0;
    end else if (alloc && !hit) begin
      valid[id] <= 1'b1;
      if (!has_free) evict_ptr <= evict_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc && !hit) keys[id] <= key;
  end

endmodule

// File: rtl/dpi_stream_sequencer.sv
// Packet-to-matcher-bus sequencer: flow lookup, state load, byte streaming, drained eop.
module dpi_stream_sequencer
  import dpi_pkg::*;
#(
  parameter int unsigned KEY_W     = 32,
  parameter int unsigned NUM_REGEX = 8,
  parameter int unsigned EOP_GAP   = EOP_GAP_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pkt_vld,
  output logic                   pkt_rdy,
  input  logic                   pkt_sop,
  input  logic                   pkt_eop,
  input  logic [7:0]             pkt_data,
  input  logic [KEY_W-1:0]       pkt_key,
  input  logic                   cfg_we,
  input  logic [STREAM_ID_W-1:0] cfg_addr,
  input  logic [NUM_REGEX-1:0]   cfg_data,
  output logic [7:0]             char_in,
  output logic                   char_in_vld,
  output logic                   load_state,
  output logic [STREAM_ID_W-1:0] stream_id,
  output logic                   new_stream_id,
  output logic [NUM_REGEX-1:0]   enable,
  output logic                   eop,
  output logic [15:0]            drop_cnt
);

  localparam int unsigned GAP_W = (EOP_GAP > 1) ? $clog2(EOP_GAP) : 1;

  seq_state_e           state;
  seq_state_e           state_d;
  logic [KEY_W-1:0]     key_q;
  logic [GAP_W-1:0]     gap_cnt;
  logic [NUM_REGEX-1:0] enable_tbl [NUM_STREAMS];
  stream_id_t           ft_id;
  logic                 ft_new;

  dpi_flow_table #(
    .KEY_W(KEY_W)
  ) u_flow_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .key      (key_q),
    .alloc    (state == S_LOOKUP),
    .id       (ft_id),
    .new_flow (ft_new)
  );

  always_comb begin
    state_d = state;
    pkt_rdy = 1'b0;
    case (state)
      S_IDLE: begin
        pkt_rdy = pkt_vld & ~pkt_sop;
        if (pkt_vld && pkt_sop) state_d = S_LOOKUP;
      end
      S_LOOKUP: state_d = S_LOAD;
      S_LOAD:   state_d = S_STREAM;
      S_STREAM: begin
        pkt_rdy = 1'b1;
        if (pkt_vld && pkt_eop) state_d = S_DRAIN;
      end
      S_DRAIN:  if (gap_cnt == '0) state_d = S_EOP;
      S_EOP:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (!rst_n) pkt_rdy = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      key_q         <= '0;
      gap_cnt       <= '0;
      char_in       <= '0;
      char_in_vld   <= 1'b0;
      load_state    <= 1'b0;
      stream_id     <= '0;
      new_stream_id <= 1'b0;
      enable        <= '0;
      eop           <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      state       <= state_d;
      load_state  <= (state_d == S_LOAD);
      eop         <= (state_d == S_EOP);
      char_in_vld <= (state == S_STREAM) && pkt_vld;
      if (state == S_STREAM && pkt_vld) char_in <= pkt_data;
      if (state == S_IDLE && pkt_vld && pkt_sop) key_q <= pkt_key;
      if (state == S_IDLE && pkt_vld && !pkt_sop && drop_cnt != '1)
        drop_cnt <= drop_cnt + 1'b1;
      // Latched from the table read during LOOKUP, so a write landing in the
      // LOAD cycle only shows up at the following packet.
      if (state == S_LOOKUP) begin
        stream_id     <= ft_id;
        new_stream_id <= ft_new;
        enable        <= enable_tbl[ft_id];
      end
      // Count starts on the eop beat so eop lands EOP_GAP cycles after its char.
      if (state == S_STREAM)     gap_cnt <= GAP_W'(EOP_GAP - 1);
      else if (state == S_DRAIN) gap_cnt <= gap_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) enable_tbl <= '{default: '0};
    else if (cfg_we) enable_tbl[cfg_addr] <= cfg_data;
  end

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Directed bench for dpi_stream_sequencer: packet table plus reset/drop/cfg hand sequences.
module tb_dpi_stream_sequencer;
  localparam int unsigned GAP = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pkt_vld, pkt_rdy, pkt_sop, pkt_eop;
  logic [7:0]  pkt_data;
  logic [31:0] pkt_key;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic [7:0]  char_in;
  logic        char_in_vld, load_state, new_stream_id, eop;
  logic [5:0]  stream_id;
  logic [7:0]  enable;
  logic [15:0] drop_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  dpi_stream_sequencer #(.KEY_W(32), .NUM_REGEX(8), .EOP_GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy), .pkt_sop(pkt_sop),
    .pkt_eop(pkt_eop), .pkt_data(pkt_data), .pkt_key(pkt_key), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .char_in(char_in), .char_in_vld(char_in_vld),
    .load_state(load_state), .stream_id(stream_id), .new_stream_id(new_stream_id),
    .enable(enable), .eop(eop), .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic [31:0] key;
    int unsigned len;
    logic [15:0] gap;
    bit          cfg_mid;
    logic [7:0]  cfg_val;
    logic [5:0]  exp_id;
    bit          exp_new;
    logic [7:0]  exp_en;
  } pkt_t;

  pkt_t vec[$];

  function automatic pkt_t mk(input logic [31:0] key, input int unsigned len,
                              input logic [15:0] gap, input bit cfg_mid, input logic [7:0] cfg_val,
                              input logic [5:0] id, input bit nw, input logic [7:0] en);
    pkt_t p;
    p.key = key; p.len = len; p.gap = gap; p.cfg_mid = cfg_mid; p.cfg_val = cfg_val;
    p.exp_id = id; p.exp_new = nw; p.exp_en = en;
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_beat(input logic [31:0] key, input int unsigned bi, input int unsigned len,
                            input bit vld);
    pkt_vld  = vld;
    pkt_sop  = (bi == 0);
    pkt_eop  = (bi == len - 1);
    pkt_data = 8'(key[7:0] + bi);
    pkt_key  = key;
  endtask

  task automatic run_pkt(input pkt_t p);
    int unsigned bi = 0, nchar = 0;
    int load_cyc = -1, first_c = -1, last_c = -1, eop_cyc = -1;
    bit done = 0, prev_acc = 0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      cfg_we = 1'b0;
      chk("char_vld_follows_beat", char_in_vld, prev_acc);
      if (load_state) begin
        chk("load_once", load_cyc, -1);
        load_cyc = cyc;
        chk("stream_id", stream_id, p.exp_id);
        chk("new_stream_id", new_stream_id, p.exp_new);
        chk("enable_at_load", enable, p.exp_en);
        if (p.cfg_mid) begin
          cfg_we = 1'b1; cfg_addr = p.exp_id; cfg_data = p.cfg_val;
        end
      end
      if (char_in_vld) begin
        chk("char_in", char_in, 8'(p.key[7:0] + nchar));
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        nchar++;
      end
      if (eop) begin
        eop_cyc = cyc;
        done = 1;
        chk("stream_id_at_eop", stream_id, p.exp_id);
        chk("enable_at_eop", enable, p.exp_en);
      end
      if (bi < p.len) drive_beat(p.key, bi, p.len, (bi == 0) || !p.gap[cyc % 16]);
      else pkt_vld = 1'b0;
      #1;
      prev_acc = pkt_vld && pkt_rdy;
      if (prev_acc) bi++;
    end
    cfg_we = 1'b0;
    chk("load_seen", load_cyc >= 0, 1);
    chk("eop_seen", eop_cyc >= 0, 1);
    chk("char_count", nchar, p.len);
    chk("eop_gap", eop_cyc - last_c, GAP);
    if (p.gap == 16'h0) chk("first_char_latency", first_c - load_cyc, 2);
    else chk("first_char_after_load", first_c >= load_cyc + 2, 1);
    @(negedge clk);
    chk("eop_one_cycle", {eop, load_state, char_in_vld}, 3'b000);
  endtask

  initial begin
    int unsigned bi, nch, rem;
    bit hit;
    rst_n = 1'b0; pkt_vld = 1'b1; pkt_sop = 1'b0; pkt_eop = 1'b0; pkt_data = 8'h11;
    pkt_key = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;

    vec.push_back(mk(32'hA5A5A5A5, 3, 16'h0, 0, 8'h00, 6'd0, 1, 8'h00));
    vec.push_back(mk(32'hA5A5A5A5, 2, 16'h0, 0, 8'h00, 6'd0, 0, 8'h00));
    vec.push_back(mk(32'h00000001, 3, 16'h0, 1, 8'hFF, 6'd1, 1, 8'h05));
    vec.push_back(mk(32'h00000001, 4, 16'h00A0, 0, 8'h00, 6'd1, 0, 8'hFF));
    for (int unsigned i = 2; i < 64; i++)
      vec.push_back(mk(32'h100 + i, 1, 16'h0, 0, 8'h00, 6'(i), 1, 8'h00));
    vec.push_back(mk(32'h00002000, 2, 16'h0, 0, 8'h00, 6'd0, 1, 8'h00));
    vec.push_back(mk(32'h00002001, 2, 16'h0, 0, 8'h00, 6'd1, 1, 8'hFF));
    vec.push_back(mk(32'hA5A5A5A5, 1, 16'h0, 0, 8'h00, 6'd2, 1, 8'h00));

    repeat (3) @(negedge clk);
    chk("rst_pkt_rdy", pkt_rdy, 0);
    chk("rst_bus", {char_in_vld, load_state, eop, new_stream_id}, 4'h0);
    chk("rst_char_in", char_in, 0);
    chk("rst_stream_id", stream_id, 0);
    chk("rst_enable", enable, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    rst_n = 1'b1;
    pkt_vld = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pkt_vld = 1'b1; pkt_sop = 1'b0; pkt_data = 8'(8'h30 + i);
      #1 chk("idle_drop_rdy", pkt_rdy, 1);
    end
    @(negedge clk);
    pkt_vld = 1'b0;
    repeat (3) begin
      chk("idle_drop_no_bus", {load_state, char_in_vld, eop}, 3'b000);
      @(negedge clk);
    end
    chk("drop_cnt", drop_cnt, 3);

    cfg_we = 1'b1; cfg_addr = 6'd1; cfg_data = 8'h05;
    @(negedge clk);
    cfg_we = 1'b0;

    foreach (vec[k]) run_pkt(vec[k]);

    bi = 0; nch = 0; hit = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      if (char_in_vld) nch++;
      if (nch == 2) hit = 1;
      else begin
        drive_beat(32'h2000, bi, 6, 1'b1);
        #1;
        if (pkt_vld && pkt_rdy) bi++;
      end
    end
    chk("mid_rst_reached", hit, 1);
    rst_n = 1'b0;
    drive_beat(32'h2000, bi, 6, 1'b1);
    #1 chk("mid_rst_rdy", pkt_rdy, 0);
    @(negedge clk);
    chk("mid_rst_bus", {char_in_vld, load_state, eop, new_stream_id}, 4'h0);
    chk("mid_rst_ids", {stream_id, enable}, 14'h0);
    rst_n = 1'b1;
    rem = 6 - bi;
    for (int c = 0; c < 20 && bi < 6; c++) begin
      drive_beat(32'h2000, bi, 6, 1'b1);
      #1;
      if (pkt_vld && pkt_rdy) bi++;
      @(negedge clk);
      chk("mid_rst_quiet", {char_in_vld, load_state, eop}, 3'b000);
    end
    pkt_vld = 1'b0;
    @(negedge clk);
    chk("mid_rst_drop_cnt", drop_cnt, rem);
    repeat (GAP + 2) begin
      @(negedge clk);
      chk("mid_rst_no_eop", eop, 0);
    end

    run_pkt(mk(32'h00002000, 2, 16'h0, 0, 8'h00, 6'd0, 1, 8'h00));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
